// File: rtl/line_fetch_ctrl.sv
// Line-fetch scheduler for the video player.
// Streams downscaled rows from external memory into a ping-pong line buffer,
// swaps banks on row boundaries paced by next_line/next_frame, and serves the
// upscaled pixel stream back to the VGA timing unit. Frame addresses advance
// per frame while play=1 and wrap after NUM_FRAMES frames.
module line_fetch_ctrl #(
   parameter int ACTIVE_W   = 640,
   parameter int ACTIVE_H   = 480,
   parameter int SCALE      = 4,
   parameter int AW         = 24,
   parameter int BASE_ADDR  = 0,
   parameter int NUM_FRAMES = 16
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic                          play,
   input  logic                          next_line,
   input  logic                          next_frame,
   input  logic [9:0]                    x_pos,
   input  logic                          blank,
   output logic                          mem_req,
   output logic [AW-1:0]                 mem_addr,
   input  logic                          mem_gnt,
   input  logic                          mem_rvalid,
   input  logic [8:0]                    mem_rdata,
   output logic [8:0]                    pix_out,
   output logic                          underrun,
   output logic [$clog2(NUM_FRAMES)-1:0] frame_idx
);

   localparam int LINE_WORDS  = ACTIVE_W / SCALE;
   localparam int ROWS        = ACTIVE_H / SCALE;
   localparam int FRAME_WORDS = LINE_WORDS * ROWS;
   localparam int SHIFT       = $clog2(SCALE);
   localparam int CW          = $clog2(LINE_WORDS);
   localparam int RW          = $clog2(ROWS);
   localparam int LCW         = $clog2(ACTIVE_H + 1);
   localparam int REPW        = (SCALE > 1) ? $clog2(SCALE) : 1;
   localparam int FIW         = $clog2(NUM_FRAMES);

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_REQ   = 2'd1;
   localparam logic [1:0] S_BURST = 2'd2;

   logic [1:0]      state;
   logic [CW-1:0]   wr_ptr;
   logic [RW-1:0]   row_idx;
   logic [AW-1:0]   row_addr;
   logic [AW-1:0]   frame_addr;
   logic            fill_ready;
   logic            rd_bank;
   logic            line_bad;
   logic [LCW-1:0]  line_cnt;
   logic [REPW-1:0] rep;

   logic [8:0] buf_mem [2][LINE_WORDS];

   logic            beat;
   logic            last_beat;
   logic            line_step;
   logic            swap;
   logic            last_row;
   logic            last_frame;
   logic [AW-1:0]   next_frame_addr;
   logic [FIW-1:0]  next_frame_idx;
   logic [9:0]      col;

   // The fill bank is always the one not being displayed. It cannot change
   // during a burst because a swap needs fill_ready, which is low until the
   // burst ends.
   assign beat      = (state == S_BURST) && mem_rvalid;
   assign last_beat = beat && (wr_ptr == CW'(LINE_WORDS - 1));

   // A row boundary is the first of SCALE repeated lines; next_frame wins if
   // both pulses ever arrive together.
   assign line_step = next_line && !next_frame && (line_cnt < LCW'(ACTIVE_H));
   assign swap      = line_step && (rep == '0) && fill_ready;

   assign last_row        = (row_idx == RW'(ROWS - 1));
   assign last_frame      = (frame_idx == FIW'(NUM_FRAMES - 1));
   assign next_frame_addr = last_frame ? AW'(BASE_ADDR) : frame_addr + AW'(FRAME_WORDS);
   assign next_frame_idx  = last_frame ? '0 : frame_idx + FIW'(1);

   assign mem_addr = row_addr;
   assign col      = x_pos >> SHIFT;

   // Fetch FSM: request a burst whenever the fill bank is free, then count beats.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state   <= S_IDLE;
         mem_req <= 1'b0;
         wr_ptr  <= '0;
      end else begin
         case (state)
            S_IDLE: begin
               if (!fill_ready) state <= S_REQ;
            end
            S_REQ: begin
               if (mem_req && mem_gnt) begin
                  state   <= S_BURST;
                  mem_req <= 1'b0;
                  wr_ptr  <= '0;
               end else begin
                  mem_req <= 1'b1;
               end
            end
            S_BURST: begin
               if (last_beat) begin
                  state  <= S_IDLE;
                  wr_ptr <= '0;
               end else if (beat) begin
                  wr_ptr <= wr_ptr + CW'(1);
               end
            end
            default: begin
               state   <= S_IDLE;
               mem_req <= 1'b0;
            end
         endcase
      end
   end

   // Row/frame address accumulators, advanced when a row finishes filling.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         row_idx    <= '0;
         row_addr   <= AW'(BASE_ADDR);
         frame_addr <= AW'(BASE_ADDR);
         frame_idx  <= '0;
      end else if (last_beat) begin
         if (last_row) begin
            row_idx <= '0;
            if (play) begin
               frame_idx  <= next_frame_idx;
               frame_addr <= next_frame_addr;
               row_addr   <= next_frame_addr;
            end else begin
               row_addr   <= frame_addr;
            end
         end else begin
            row_idx  <= row_idx + RW'(1);
            row_addr <= row_addr + AW'(LINE_WORDS);
         end
      end
   end

   // Beat capture into the fill bank.
   // NOTE: the line buffer has no reset; only its write enable is held off
   // during reset so beats arriving then are dropped.
   always_ff @(posedge clk) begin
      if (rst_n && beat) buf_mem[~rd_bank][wr_ptr] <= mem_rdata;
   end

   // Line sequencing: bank swap on row boundaries, underrun flagging.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         fill_ready <= 1'b0;
         rd_bank    <= 1'b0;
         line_bad   <= 1'b1;
         underrun   <= 1'b0;
         line_cnt   <= '0;
         rep        <= '0;
      end else begin
         if (last_beat)  fill_ready <= 1'b1;
         else if (swap)  fill_ready <= 1'b0;

         if (next_frame) begin
            line_cnt <= '0;
            rep      <= '0;
         end else if (line_step) begin
            if (rep == '0) begin
               if (fill_ready) begin
                  rd_bank  <= ~rd_bank;
                  line_bad <= 1'b0;
               end else begin
                  line_bad <= 1'b1;
                  underrun <= 1'b1;
               end
            end
            rep      <= (rep == REPW'(SCALE - 1)) ? '0 : rep + REPW'(1);
            line_cnt <= line_cnt + LCW'(1);
         end
      end
   end

   // Registered pixel output: horizontal upscale by dropping the low x bits.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         pix_out <= '0;
      end else if (blank || line_bad || (col >= 10'(LINE_WORDS))) begin
         pix_out <= '0;
      end else begin
         pix_out <= buf_mem[rd_bank][col[CW-1:0]];
      end
   end

endmodule

// File: tb/tb_line_fetch_ctrl.sv
// Directed bench for line_fetch_ctrl: reset, first swap, pixel mapping, row
// repeat, underrun (including last beat coinciding with a row boundary),
// mid-burst reset and frame wrap with NUM_FRAMES=2.
module tb_line_fetch_ctrl;

   localparam int AW    = 24;
   localparam int LW    = 160;
   localparam int ROWS  = 120;
   localparam int FRAME = 19200;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          play;
   logic          next_line;
   logic          next_frame;
   logic [9:0]    x_pos;
   logic          blank;
   logic          mem_req;
   logic [AW-1:0] mem_addr;
   logic          mem_gnt;
   logic          mem_rvalid;
   logic [8:0]    mem_rdata;
   logic [8:0]    pix_out;
   logic          underrun;
   logic [0:0]    frame_idx;

   int n_checks = 0;
   int n_fails  = 0;

   always #5 clk = ~clk;

   line_fetch_ctrl #(.NUM_FRAMES(2)) u_dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .play       (play),
      .next_line  (next_line),
      .next_frame (next_frame),
      .x_pos      (x_pos),
      .blank      (blank),
      .mem_req    (mem_req),
      .mem_addr   (mem_addr),
      .mem_gnt    (mem_gnt),
      .mem_rvalid (mem_rvalid),
      .mem_rdata  (mem_rdata),
      .pix_out    (pix_out),
      .underrun   (underrun),
      .frame_idx  (frame_idx)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fails++;
         $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
      end
   endtask

   task automatic pulse_line();
      next_line = 1'b1;
      tick();
      next_line = 1'b0;
   endtask

   task automatic pulse_frame();
      next_frame = 1'b1;
      tick();
      next_frame = 1'b0;
   endtask

   task automatic show(input logic [9:0] x, input logic b);
      x_pos = x;
      blank = b;
      tick();
   endtask

   task automatic send_beats(input logic [8:0] base, input int n);
      for (int i = 0; i < n; i++) begin
         mem_rvalid = 1'b1;
         mem_rdata  = base + 9'(i);
         tick();
      end
      mem_rvalid = 1'b0;
   endtask

   // Wait (bounded) for a request, check its address, grant it.
   task automatic req_grant(input string tag, input int exp_addr);
      int k = 0;
      while (mem_req !== 1'b1 && k < 20) begin
         tick();
         k++;
      end
      check({tag, "_req"}, 32'(mem_req), 1);
      check({tag, "_addr"}, 32'(mem_addr), exp_addr);
      mem_gnt = 1'b1;
      tick();
      mem_gnt = 1'b0;
   endtask

   task automatic serve_row(input string tag, input logic [8:0] base, input int exp_addr);
      req_grant(tag, exp_addr);
      send_beats(base, LW);
   endtask

   // Fetch rows first_row..ROWS-1 of a frame, swapping after each but the last.
   task automatic run_frame(input string tag, input int frame_base, input int first_row);
      for (int r = first_row; r < ROWS; r++) begin
         serve_row(tag, 9'(r), frame_base + r * LW);
         if (r < ROWS - 1) begin
            pulse_frame();
            pulse_line();
         end
      end
   endtask

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n = 1'b0; play = 1'b0; next_line = 1'b0; next_frame = 1'b0;
      x_pos = '0; blank = 1'b1; mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
      repeat (3) tick();

      // 1. Reset values and first fetch / first swap
      check("rst_mem_req", 32'(mem_req), 0);
      check("rst_mem_addr", 32'(mem_addr), 0);
      check("rst_pix_out", 32'(pix_out), 0);
      check("rst_underrun", 32'(underrun), 0);
      check("rst_frame_idx", 32'(frame_idx), 0);
      rst_n = 1'b1;
      tick();
      check("req_in_req_state", 32'(mem_req), 0);
      tick();
      check("req_rise", 32'(mem_req), 1);
      check("first_addr", 32'(mem_addr), 0);
      tick();
      tick();
      mem_gnt = 1'b1;
      tick();
      mem_gnt = 1'b0;
      check("req_fall_after_gnt", 32'(mem_req), 0);
      send_beats(9'd0, LW);
      repeat (3) tick();
      check("no_fetch_fill_full", 32'(mem_req), 0);
      pulse_frame();
      pulse_line();
      tick();
      check("req_after_swap_lat", 32'(mem_req), 0);
      tick();
      check("req_after_swap", 32'(mem_req), 1);
      check("second_addr", 32'(mem_addr), 160);

      // 2. Pixel mapping (row 0 holds beat index)
      for (int x = 0; x < 4; x++) begin
         show(10'(x), 1'b0);
         check("pix_x0_3", 32'(pix_out), 0);
      end
      show(10'd4, 1'b0);
      check("pix_x4", 32'(pix_out), 1);
      show(10'd639, 1'b0);
      check("pix_x639", 32'(pix_out), 159);
      show(10'd639, 1'b1);
      check("pix_blank", 32'(pix_out), 0);

      // 3. Row repeat: pulses 2..4 of row 0 keep the bank, the 5th swaps
      serve_row("row1", 9'd256, 160);
      x_pos = 10'd8;
      blank = 1'b0;
      for (int i = 0; i < 3; i++) begin
         pulse_line();
         tick();
         tick();
         check("rep_pix_row0", 32'(pix_out), 2);
         check("rep_no_fetch", 32'(mem_req), 0);
      end
      pulse_line();
      tick();
      check("swap_pix_row1", 32'(pix_out), 258);
      tick();
      check("third_req", 32'(mem_req), 1);
      check("third_addr", 32'(mem_addr), 320);

      // 4. Underrun: grant withheld across the next row boundary
      for (int i = 0; i < 3; i++) begin
         pulse_line();
         tick();
         check("pre_underrun_pix", 32'(pix_out), 258);
      end
      check("pre_underrun_flag", 32'(underrun), 0);
      pulse_line();
      check("underrun_set", 32'(underrun), 1);
      tick();
      check("underrun_pix_l0", 32'(pix_out), 0);
      for (int i = 0; i < 3; i++) begin
         pulse_line();
         tick();
         check("underrun_pix_l123", 32'(pix_out), 0);
      end
      serve_row("row2", 9'h080, 320);
      tick();
      check("late_row_not_yet", 32'(pix_out), 0);
      pulse_line();
      tick();
      check("late_row_shown", 32'(pix_out), 130);
      check("underrun_sticky", 32'(underrun), 1);

      // Last beat coinciding with a row boundary counts as not ready
      for (int i = 0; i < 3; i++) pulse_line();
      req_grant("row3", 480);
      send_beats(9'h040, LW - 1);
      mem_rvalid = 1'b1;
      mem_rdata  = 9'h040 + 9'd159;
      next_line  = 1'b1;
      tick();
      mem_rvalid = 1'b0;
      next_line  = 1'b0;
      tick();
      check("same_cycle_underrun_pix", 32'(pix_out), 0);
      for (int i = 0; i < 3; i++) pulse_line();
      pulse_line();
      tick();
      check("same_cycle_row_shown", 32'(pix_out), 66);

      // 6. Mid-burst reset at beat 50, 20 stale beats before the next grant
      req_grant("row4", 640);
      send_beats(9'h100, 50);
      rst_n      = 1'b0;
      mem_rvalid = 1'b1;
      mem_rdata  = 9'h1FF;
      tick();
      check("rst_mid_req", 32'(mem_req), 0);
      tick();
      check("rst_mid_req2", 32'(mem_req), 0);
      check("rst_mid_addr", 32'(mem_addr), 0);
      check("rst_mid_underrun", 32'(underrun), 0);
      rst_n = 1'b1;
      repeat (18) tick();
      mem_rvalid = 1'b0;
      blank = 1'b1;
      serve_row("post_rst", 9'h020, 0);
      pulse_frame();
      pulse_line();
      show(10'd0, 1'b0);
      check("post_rst_pix0", 32'(pix_out), 32);
      show(10'd200, 1'b0);
      check("post_rst_pix50", 32'(pix_out), 82);
      show(10'd636, 1'b0);
      check("post_rst_pix159", 32'(pix_out), 191);
      blank = 1'b1;

      // 5. Frame wrap: play=0 repeats frame 0, then play=1 walks 0 -> 1 -> 0
      run_frame("f0_hold", 0, 1);
      check("play0_wrap_addr", 32'(mem_addr), 0);
      check("play0_frame_idx", 32'(frame_idx), 0);
      play = 1'b1;
      pulse_frame();
      pulse_line();
      run_frame("f0_play", 0, 0);
      check("wrap_f1_addr", 32'(mem_addr), FRAME);
      check("wrap_f1_idx", 32'(frame_idx), 1);
      pulse_frame();
      pulse_line();
      run_frame("f1_play", FRAME, 0);
      check("wrap_f0_addr", 32'(mem_addr), 0);
      check("wrap_f0_idx", 32'(frame_idx), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
      $finish;
   end

endmodule
